// File: rtl/iir_biquad_seq_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// iir_biquad_seq_if: sample, result and coefficient-config signals of the
// time-multiplexed biquad cascade.  Revision: 1.0
// ----------------------------------------------------------------------------
interface iir_biquad_seq_if #(
  parameter int SECTIONS = 2,
  parameter int BITWIDTH = 32
);
  localparam int ADDR_W = $clog2(5 * SECTIONS);

  logic signed [BITWIDTH-1:0] x;
  logic                       x_valid;
  logic                       x_ready;
  logic signed [BITWIDTH-1:0] y;
  logic                       y_valid;
  logic                       y_ready;
  logic                       cfg_we;
  logic [ADDR_W-1:0]          cfg_addr;
  logic signed [BITWIDTH-1:0] cfg_data;
  logic                       busy;

  modport master (
    output x, x_valid, y_ready, cfg_we, cfg_addr, cfg_data,
    input  x_ready, y, y_valid, busy
  );

  modport slave (
    input  x, x_valid, y_ready, cfg_we, cfg_addr, cfg_data,
    output x_ready, y, y_valid, busy
  );
endinterface
`default_nettype wire

// File: rtl/iir_biquad_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// iir_biquad_seq: cascade of Q20 direct-form-II biquads sharing one MAC,
// six cycles per section.  Revision: 1.0
// ----------------------------------------------------------------------------
module iir_biquad_seq #(
  parameter int SECTIONS = 2,
  parameter int BITWIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  iir_biquad_seq_if.slave  bus
);
  localparam int W    = BITWIDTH;
  localparam int AW   = $clog2(5 * SECTIONS);
  localparam int CN   = 1 << AW;
  localparam int SW   = (SECTIONS > 1) ? $clog2(SECTIONS) : 1;
  localparam int ZN   = 1 << SW;
  localparam int FRAC = 20;
  localparam logic [AW:0]   NCOEF  = (AW+1)'(5 * SECTIONS);
  localparam logic [SW-1:0] LAST_S = SW'(SECTIONS - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0, FB1 = 3'd1, FB2 = 3'd2, FF0 = 3'd3,
    FF1  = 3'd4, FF2 = 3'd5, UPD = 3'd6, DONE = 3'd7
  } state_t;

  state_t                 state_q, state_d;
  logic signed [W-1:0]    coef_q [CN];
  logic signed [W-1:0]    coef_d [CN];
  logic signed [2*W-1:0]  z1_q [ZN];
  logic signed [2*W-1:0]  z1_d [ZN];
  logic signed [2*W-1:0]  z2_q [ZN];
  logic signed [2*W-1:0]  z2_d [ZN];
  logic signed [W-1:0]    acc_in_q, acc_in_d;
  logic signed [W-1:0]    y_q, y_d;
  logic signed [2*W-1:0]  acc_q, acc_d;
  logic signed [2*W-1:0]  w1_q, w1_d;
  logic [SW-1:0]          s_q, s_d;
  logic                   y_valid_q, y_valid_d;

  logic [AW-1:0]          base, cidx;
  logic [2:0]             k;
  logic signed [W-1:0]    c_sel;
  logic signed [2*W-1:0]  c_ext, op_sel, prod, in_ext, fb2_res;
  logic signed [W-1:0]    sec_out;

  // Single shared multiplier: the state picks coefficient and operand.
  always_comb begin
    k      = 3'd0;
    op_sel = w1_q;
    unique case (state_q)
      FB1:     begin k = 3'd3; op_sel = z1_q[s_q]; end
      FB2:     begin k = 3'd4; op_sel = z2_q[s_q]; end
      FF1:     begin k = 3'd1; op_sel = z1_q[s_q]; end
      FF2:     begin k = 3'd2; op_sel = z2_q[s_q]; end
      default: ;
    endcase
    base    = AW'(s_q) * AW'(5);
    cidx    = base + AW'(k);
    c_sel   = coef_q[cidx];
    c_ext   = {{W{c_sel[W-1]}}, c_sel};
    prod    = c_ext * op_sel;
    in_ext  = {{W{acc_in_q[W-1]}}, acc_in_q} <<< FRAC;
    fb2_res = acc_q - prod;
    sec_out = W'(acc_q >>> (FRAC + 4));
  end

  always_comb begin
    state_d   = state_q;
    coef_d    = coef_q;
    z1_d      = z1_q;
    z2_d      = z2_q;
    acc_in_d  = acc_in_q;
    acc_d     = acc_q;
    w1_d      = w1_q;
    s_d       = s_q;
    y_d       = y_q;
    y_valid_d = y_valid_q;

    // Coefficients only change while idle, so a sample never sees a mixed set.
    if (bus.cfg_we && (state_q == IDLE) && ({1'b0, bus.cfg_addr} < NCOEF)) begin
      coef_d[bus.cfg_addr] = bus.cfg_data;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.x_valid) begin
          acc_in_d = bus.x;
          s_d      = '0;
          state_d  = FB1;
        end
      end
      FB1: begin
        acc_d   = in_ext - prod;
        state_d = FB2;
      end
      FB2: begin
        w1_d    = fb2_res >>> FRAC;
        acc_d   = '0;
        state_d = FF0;
      end
      FF0: begin
        acc_d   = prod;
        state_d = FF1;
      end
      FF1: begin
        acc_d   = acc_q + prod;
        state_d = FF2;
      end
      FF2: begin
        acc_d   = acc_q + prod;
        state_d = UPD;
      end
      UPD: begin
        z2_d[s_q] = z1_q[s_q];
        z1_d[s_q] = w1_q;
        if (s_q != LAST_S) begin
          acc_in_d = sec_out;
          s_d      = s_q + SW'(1);
          state_d  = FB1;
        end else begin
          y_d       = sec_out;
          y_valid_d = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (bus.y_ready) begin
          y_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      for (int i = 0; i < CN; i++) coef_q[i] <= '0;
      for (int i = 0; i < ZN; i++) begin
        z1_q[i] <= '0;
        z2_q[i] <= '0;
      end
      acc_in_q  <= '0;
      acc_q     <= '0;
      w1_q      <= '0;
      s_q       <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      coef_q    <= coef_d;
      z1_q      <= z1_d;
      z2_q      <= z2_d;
      acc_in_q  <= acc_in_d;
      acc_q     <= acc_d;
      w1_q      <= w1_d;
      s_q       <= s_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign bus.x_ready = (state_q == IDLE);
  assign bus.busy    = (state_q != IDLE);
  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;
endmodule
`default_nettype wire

// File: tb/tb_iir_biquad_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_iir_biquad_seq: scoreboard bench for two-section and one-section cascades.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_iir_biquad_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  iir_biquad_seq_if #(.SECTIONS(2), .BITWIDTH(32)) ifa ();
  iir_biquad_seq_if #(.SECTIONS(1), .BITWIDTH(32)) ifb ();

  iir_biquad_seq #(.SECTIONS(2), .BITWIDTH(32)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  iir_biquad_seq #(.SECTIONS(1), .BITWIDTH(32)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  int checks   = 0;
  int failures = 0;
  int exp_q[$];

  // Reference cascade for the two-section DUT, updated on every accepted sample.
  int     mc [10];
  longint mz1[2];
  longint mz2[2];

  task automatic check_result(input string tag, input logic signed [63:0] obs,
                              input logic signed [63:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int model_step(input int x);
    longint acc, w;
    int v;
    v = x;
    for (int s = 0; s < 2; s++) begin
      acc = longint'(v) <<< 20;
      acc = acc - longint'(mc[s*5+3]) * mz1[s];
      acc = acc - longint'(mc[s*5+4]) * mz2[s];
      w   = acc >>> 20;
      acc = longint'(mc[s*5]) * w + longint'(mc[s*5+1]) * mz1[s]
          + longint'(mc[s*5+2]) * mz2[s];
      mz2[s] = mz1[s];
      mz1[s] = w;
      v = int'(acc >>> 24);
    end
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 10; i++) mc[i] = 0;
    for (int i = 0; i < 2; i++) begin
      mz1[i] = 0;
      mz2[i] = 0;
    end
  endtask

  task automatic cfg_a(input int addr, input int data);
    ifa.cfg_we = 1'b1; ifa.cfg_addr = 4'(addr); ifa.cfg_data = data;
    @(negedge clk);
    ifa.cfg_we = 1'b0;
    if (addr < 10) mc[addr] = data;
  endtask

  task automatic cfg_b(input int addr, input int data);
    ifb.cfg_we = 1'b1; ifb.cfg_addr = 3'(addr); ifb.cfg_data = data;
    @(negedge clk);
    ifb.cfg_we = 1'b0;
  endtask

  // One sample through the two-section DUT; optional backpressure and busy write.
  task automatic run_a(input int x, input int exp_const, input bit use_model,
                       input int hold, input bit busy_wr);
    int lat, m, expv;
    lat = 0;
    while (!ifa.x_ready && lat < 100) begin @(negedge clk); lat++; end
    check_result("a_xready", ifa.x_ready, 1);
    m = model_step(x);
    exp_q.push_back(use_model ? m : exp_const);
    ifa.x = x; ifa.x_valid = 1'b1;
    @(negedge clk);
    ifa.x_valid = 1'b0;
    lat = 1;
    check_result("a_busy", ifa.busy, 1);
    while (!ifa.y_valid && lat < 200) begin
      if (busy_wr && lat == 4) begin
        ifa.cfg_we = 1'b1; ifa.cfg_addr = 4'd0; ifa.cfg_data = 0;
      end
      @(negedge clk);
      ifa.cfg_we = 1'b0;
      lat++;
    end
    check_result("a_latency", lat, 13);
    expv = exp_q.pop_front();
    check_result("a_y", ifa.y, expv);
    if (hold > 0) begin
      ifa.x = x + 7; ifa.x_valid = 1'b1;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_result("a_hold_y", ifa.y, expv);
      check_result("a_hold_valid", ifa.y_valid, 1);
      check_result("a_hold_xready", ifa.x_ready, 0);
    end
    ifa.x_valid = 1'b0; ifa.y_ready = 1'b1;
    @(negedge clk);
    ifa.y_ready = 1'b0;
    check_result("a_idle_xready", ifa.x_ready, 1);
    check_result("a_valid_low", ifa.y_valid, 0);
    check_result("a_y_keep", ifa.y, expv);
  endtask

  task automatic run_b(input int x, input int expv, input bit cfg_en,
                       input int addr, input int data);
    int lat;
    lat = 0;
    while (!ifb.x_ready && lat < 100) begin @(negedge clk); lat++; end
    exp_q.push_back(expv);
    ifb.x = x; ifb.x_valid = 1'b1;
    if (cfg_en) begin
      ifb.cfg_we = 1'b1; ifb.cfg_addr = 3'(addr); ifb.cfg_data = data;
    end
    @(negedge clk);
    ifb.x_valid = 1'b0; ifb.cfg_we = 1'b0;
    lat = 1;
    while (!ifb.y_valid && lat < 100) begin @(negedge clk); lat++; end
    check_result("b_latency", lat, 7);
    check_result("b_y", ifb.y, exp_q.pop_front());
    ifb.y_ready = 1'b1;
    @(negedge clk);
    ifb.y_ready = 1'b0;
  endtask

  task automatic reset_mid_a(input int x);
    ifa.x = x; ifa.x_valid = 1'b1;
    @(negedge clk);
    ifa.x_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_result("rst_xready", ifa.x_ready, 1);
    check_result("rst_y_valid", ifa.y_valid, 0);
    check_result("rst_busy", ifa.busy, 0);
    check_result("rst_y", ifa.y, 0);
    model_clear();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ifa.x = 0; ifa.x_valid = 0; ifa.y_ready = 0; ifa.cfg_we = 0; ifa.cfg_addr = 0; ifa.cfg_data = 0;
    ifb.x = 0; ifb.x_valid = 0; ifb.y_ready = 0; ifb.cfg_we = 0; ifb.cfg_addr = 0; ifb.cfg_data = 0;
    model_clear();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check_result("reset_a_xready", ifa.x_ready, 1);
    check_result("reset_a_valid", ifa.y_valid, 0);
    check_result("reset_a_y", ifa.y, 0);
    check_result("reset_a_busy", ifa.busy, 0);
    check_result("reset_b_xready", ifb.x_ready, 1);
    check_result("reset_b_valid", ifb.y_valid, 0);
    check_result("reset_b_y", ifb.y, 0);
    check_result("reset_b_busy", ifb.busy, 0);

    // Passthrough: each section divides by 16 with floor rounding.
    cfg_a(0, 1 << 20);
    cfg_a(5, 1 << 20);
    run_a(1600, 6, 0, 0, 0);
    run_a(-1600, -7, 0, 0, 0);
    run_a(1600, 6, 0, 10, 0);
    run_a(1600, 6, 0, 0, 1);
    cfg_a(10, 12345);
    run_a(1600, 6, 0, 0, 0);

    reset_mid_a(1600);
    run_a(1600, 0, 0, 0, 0);
    cfg_a(0, 1 << 20);
    cfg_a(5, 1 << 20);
    run_a(1600, 6, 0, 0, 0);

    // Full coefficient set, checked against the reference cascade.
    cfg_a(0, 1 << 19);     cfg_a(1, 1 << 18);     cfg_a(2, 1 << 17);
    cfg_a(3, -(1 << 18));  cfg_a(4, 1 << 17);
    cfg_a(5, 3 << 19);     cfg_a(6, -(1 << 18));  cfg_a(7, 1 << 16);
    cfg_a(8, 1 << 18);     cfg_a(9, -(1 << 17));
    for (int i = 0; i < 6; i++) begin
      run_a(((i % 2) == 1 ? -1 : 1) * (4000000 + 300000 * i), 0, 1, 0, 0);
    end

    // Recursive impulse on the one-section DUT.
    cfg_b(0, 1 << 20);
    cfg_b(3, -(1 << 19));
    run_b(256, 16, 0, 0, 0);
    run_b(0, 8, 0, 0, 0);
    run_b(0, 4, 0, 0, 0);
    run_b(0, 2, 0, 0, 0);
    // Most negative input; a1 cleared in the accept cycle so z1 has no effect.
    run_b(32'sh80000000, -134217728, 1, 3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
